// File: rtl/sm_addsub_sequencer.sv
// Multi-cycle signed-magnitude adder/subtractor.
// One W-bit slice is reused LSB chunk first; a swap pass runs when |A| < |B| on the subtract path.
module sm_addsub_sequencer #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         overflow,
  output logic         busy
);

  localparam int K  = (N - 1 + W - 1) / W;
  localparam int M  = K * W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cy_q, cy_d;
  logic [M-1:0]  mag_a_q, mag_a_d;
  logic [M-1:0]  mag_b_q, mag_b_d;
  logic [M-1:0]  res_q, res_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic          eff_sub_q, eff_sub_d;
  logic [N-1:0]  c_q, c_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  a_chunk [K];
  logic [W-1:0]  b_chunk [K];
  logic [W-1:0]  slice_x, slice_y;
  logic [W:0]    slice_sum;
  logic          slice_cout;
  logic [M-1:0]  res_wr;
  logic          mag_carry;
  logic          res_zero;
  logic          res_sign;

  for (genvar gi = 0; gi < K; gi++) begin : g_chunk
    assign a_chunk[gi] = mag_a_q[gi*W +: W];
    assign b_chunk[gi] = mag_b_q[gi*W +: W];
  end

  // The swap pass simply exchanges the slice operands.
  always_comb begin
    slice_x = a_chunk[idx_q];
    slice_y = b_chunk[idx_q];
    if (state_q == PASS2) begin
      slice_x = b_chunk[idx_q];
      slice_y = a_chunk[idx_q];
    end
    if (eff_sub_q) begin
      slice_sum = {1'b0, slice_x} - {1'b0, slice_y} - {{W{1'b0}}, cy_q};
    end else begin
      slice_sum = {1'b0, slice_x} + {1'b0, slice_y} + {{W{1'b0}}, cy_q};
    end
    slice_cout = slice_sum[W];
  end

  always_comb begin
    res_wr = res_q;
    for (int i = 0; i < K; i++) begin
      if (idx_q == IW'(i)) begin
        res_wr[i*W +: W] = slice_sum[W-1:0];
      end
    end
  end

  // Carry out of magnitude bit N-2: the slice carry when the magnitude fills
  // the chunks exactly, otherwise the first zero-padding bit of the sum.
  if (M == N - 1) begin : g_carry_exact
    assign mag_carry = slice_cout;
  end else begin : g_carry_padded
    assign mag_carry = res_wr[N-1];
  end

  assign res_zero = (res_wr[N-2:0] == '0);
  assign res_sign = (state_q == PASS2) ? sign_b_q : sign_a_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    res_d     = res_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    eff_sub_d = eff_sub_q;
    c_d       = c_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_a_d   = M'(a[N-2:0]);
          mag_b_d   = M'(b[N-2:0]);
          sign_a_d  = a[N-1];
          sign_b_d  = b[N-1] ^ op;
          eff_sub_d = a[N-1] ^ b[N-1] ^ op;
          idx_d     = '0;
          cy_d      = 1'b0;
          res_d     = '0;
          ovf_d     = 1'b0;
          state_d   = PASS1;
        end
      end

      PASS1, PASS2: begin
        res_d = res_wr;
        cy_d  = slice_cout;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          cy_d  = 1'b0;
          if ((state_q == PASS1) && eff_sub_q && slice_cout) begin
            // |A| < |B|: redo as |B| - |A| and take B's effective sign.
            state_d = PASS2;
          end else begin
            state_d = DONE;
            ovf_d   = (state_q == PASS1) && !eff_sub_q && mag_carry;
            c_d     = {res_sign & ~res_zero, res_wr[N-2:0]};
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cy_q      <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      res_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      eff_sub_q <= 1'b0;
      c_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cy_q      <= cy_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      res_q     <= res_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      eff_sub_q <= eff_sub_d;
      c_q       <= c_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign c         = c_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sm_addsub_sequencer.sv
// Scoreboard bench for sm_addsub_sequencer (N=32, W=8, K=4).
module tb_sm_addsub_sequencer;

  localparam int N = 32;
  localparam int W = 8;
  localparam int K = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] c;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb_q[$];

  sm_addsub_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on sign and magnitude.
  function automatic exp_t model(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic top);
    exp_t         e;
    logic [N-1:0] ma, mb, sum;
    logic         sa, sb, sgn;
    logic [N-2:0] mag;
    ma  = {1'b0, ta[N-2:0]};
    mb  = {1'b0, tb[N-2:0]};
    sa  = ta[N-1];
    sb  = tb[N-1] ^ top;
    e.ovf = 1'b0;
    e.lat = K;
    if (sa == sb) begin
      sum   = ma + mb;
      e.ovf = sum[N-1];
      mag   = sum[N-2:0];
      sgn   = sa;
    end else if (ma >= mb) begin
      sum = ma - mb;
      mag = sum[N-2:0];
      sgn = sa;
    end else begin
      sum   = mb - ma;
      mag   = sum[N-2:0];
      sgn   = sb;
      e.lat = 2 * K;
    end
    if (mag == '0) sgn = 1'b0;
    e.c = {sgn, mag};
    return e;
  endfunction

  task automatic accept_txn(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic top);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    op       = top;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid; -1 if the budget expires.
  task automatic wait_out(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL reset_c got %h want 00000000", c); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: in_ready=%b out_valid=%b c=%h busy=%b", in_ready, out_valid, c, busy);
  endtask

  task automatic test_directed;
    logic [N-1:0] va [5] = '{32'h00000005, 32'h00000003, 32'h7FFFFFFF, 32'h00000007, 32'h80000000};
    logic [N-1:0] vb [5] = '{32'h00000003, 32'h00000005, 32'h00000001, 32'h80000007, 32'h00000000};
    logic         vo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] vc [5] = '{32'h00000008, 32'h80000002, 32'h00000000, 32'h00000000, 32'h00000000};
    logic         vv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int           vl [5] = '{4, 8, 4, 4, 4};
    int           cyc;
    exp_t         e;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{c: vc[i], ovf: vv[i], lat: vl[i]});
      accept_txn(va[i], vb[i], vo[i]);
      wait_out(cyc);
      e = sb_q.pop_front();
      checks++; if (cyc !== e.lat) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, cyc, e.lat); end
      checks++; if (c !== e.c) begin errors++; $display("FAIL directed%0d_c got %h want %h", i, c, e.c); end
      checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL directed%0d_overflow got %b want %b", i, overflow, e.ovf); end
      $display("directed%0d: a=%h b=%h op=%b -> c=%h ovf=%b lat=%0d", i, va[i], vb[i], vo[i], c, overflow, cyc);
      release_out;
    end
  endtask

  task automatic test_backpressure;
    int   cyc;
    exp_t e;
    sb_q.push_back(model(32'h00000010, 32'h00000004, 1'b1));
    accept_txn(32'h00000010, 32'h00000004, 1'b1);
    wait_out(cyc);
    e = sb_q.pop_front();
    checks++; if (cyc !== e.lat) begin errors++; $display("FAIL bp_latency got %0d want %0d", cyc, e.lat); end
    in_valid = 1'b1;
    a        = 32'h7FFFFFFF;
    b        = 32'hFFFFFFFF;
    op       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc%0d got %b want 1", i, out_valid); end
      checks++; if (c !== e.c) begin errors++; $display("FAIL bp_c cyc%0d got %h want %h", i, c, e.c); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_out;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", busy); end
    $display("backpressure: held c=%h for 10 cycles, in_ready after release=%b", e.c, in_ready);
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] ta, tb;
    logic         top;
    int           cyc;
    exp_t         e;
    for (int i = 0; i < 24; i++) begin
      ta = $urandom;
      case (i % 4)
        0:       tb = {$urandom_range(0, 1) == 1, ta[N-2:0]};
        1:       tb = {$urandom_range(0, 1) == 1, 31'h7FFFFFFF};
        default: tb = $urandom;
      endcase
      top = ($urandom_range(0, 1) == 1);
      sb_q.push_back(model(ta, tb, top));
      accept_txn(ta, tb, top);
      wait_out(cyc);
      e = sb_q.pop_front();
      checks++; if (cyc !== e.lat) begin errors++; $display("FAIL b2b%0d_latency got %0d want %0d", i, cyc, e.lat); end
      checks++; if (c !== e.c) begin errors++; $display("FAIL b2b%0d_c got %h want %h", i, c, e.c); end
      checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL b2b%0d_overflow got %b want %b", i, overflow, e.ovf); end
      $display("b2b%0d: a=%h b=%h op=%b -> c=%h ovf=%b lat=%0d", i, ta, tb, top, c, overflow, cyc);
      release_out;
    end
  endtask

  task automatic test_reset_mid_op;
    int   cyc;
    exp_t e;
    sb_q.push_back(model(32'h00000003, 32'h00000005, 1'b1));
    accept_txn(32'h00000003, 32'h00000005, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL midrst_c got %h want 00000000", c); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b want 0", overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b want 0", out_valid); end
    end
    sb_q.push_back('{c: 32'h00000008, ovf: 1'b0, lat: K});
    accept_txn(32'h00000005, 32'h00000003, 1'b0);
    wait_out(cyc);
    e = sb_q.pop_front();
    checks++; if (cyc !== e.lat) begin errors++; $display("FAIL midrst_add_latency got %0d want %0d", cyc, e.lat); end
    checks++; if (c !== e.c) begin errors++; $display("FAIL midrst_add_c got %h want %h", c, e.c); end
    checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL midrst_add_overflow got %b want %b", overflow, e.ovf); end
    $display("reset_mid_op: post-reset add c=%h lat=%0d", c, cyc);
    release_out;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_directed;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
